// File: rtl/canny_pkg.sv
// Shared types, width helper and defaults for the Canny frame sequencer.
package canny_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1048576;

  function automatic int cnt_width(input int width, input int height);
    return $clog2(width * height + 1);
  endfunction

endpackage

// File: rtl/canny_pixel_gate.sv
// One side of the frame sequencer: opens a FIFO-to-FIFO path and counts
// transfers until exactly N pixels have passed.
module canny_pixel_gate #(
  parameter int DATA_W = 8,
  parameter int N      = 8,
  parameter int CNT_W  = $clog2(N + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              empty,
  input  logic              full,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              xfer,
  output logic [CNT_W-1:0]  cnt,
  output logic              limit_reached
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(N);

  assign limit_reached = (cnt >= LIMIT);
  assign xfer          = enable & ~empty & ~full & ~limit_reached;
  assign dout          = din;

  // A clear in the same cycle as a transfer wins: that transfer closed the old frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (xfer) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/canny_frame_sequencer.sv
// Meters one WIDTH x HEIGHT frame into the Canny pipeline and drains one frame
// of results out of it, with start/abort/continuous control and a stall watchdog.
module canny_frame_sequencer
  import canny_pkg::*;
#(
  parameter int WIDTH          = 1280,
  parameter int HEIGHT         = 720,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        continuous,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] frame_count,
  input  logic        src_empty,
  input  logic [23:0] src_dout,
  output logic        src_rd_en,
  input  logic        image_full,
  output logic        image_wr_en,
  output logic [23:0] image_din,
  input  logic        img_out_empty,
  input  logic [7:0]  img_out_dout,
  output logic        img_out_rd_en,
  input  logic        dst_full,
  output logic        dst_wr_en,
  output logic [7:0]  dst_din
);

  localparam int N       = WIDTH * HEIGHT;
  localparam int CNT_W   = cnt_width(WIDTH, HEIGHT);
  localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   LAST        = CNT_W'(N - 1);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);

  state_t state, state_next;

  logic               run;
  logic               cnt_clear;
  logic               in_xfer;
  logic               out_xfer;
  logic               frame_end;
  logic               stall_timeout;
  logic [CNT_W-1:0]   out_cnt;
  logic [CNT_W-1:0]   in_cnt_unused;
  logic               in_limit_unused;
  logic               out_limit_unused;
  logic [STALL_W-1:0] stall_cnt;

  // Abort closes both gates in the very cycle it is seen.
  assign run           = (state == RUN) && !abort;
  assign frame_end     = out_xfer && (out_cnt == LAST);
  assign stall_timeout = run && !out_xfer && (stall_cnt == STALL_LIMIT);
  assign cnt_clear     = abort || frame_end || ((state == IDLE) && start);

  canny_pixel_gate #(.DATA_W(24), .N(N), .CNT_W(CNT_W)) u_in_gate (
    .clock         (clock),
    .reset         (reset),
    .enable        (run),
    .clear         (cnt_clear),
    .empty         (src_empty),
    .full          (image_full),
    .din           (src_dout),
    .dout          (image_din),
    .xfer          (in_xfer),
    .cnt           (in_cnt_unused),
    .limit_reached (in_limit_unused)
  );

  canny_pixel_gate #(.DATA_W(8), .N(N), .CNT_W(CNT_W)) u_out_gate (
    .clock         (clock),
    .reset         (reset),
    .enable        (run),
    .clear         (cnt_clear),
    .empty         (img_out_empty),
    .full          (dst_full),
    .din           (img_out_dout),
    .dout          (dst_din),
    .xfer          (out_xfer),
    .cnt           (out_cnt),
    .limit_reached (out_limit_unused)
  );

  assign src_rd_en     = in_xfer;
  assign image_wr_en   = in_xfer;
  assign img_out_rd_en = out_xfer;
  assign dst_wr_en     = out_xfer;
  assign busy          = (state == RUN);
  assign error         = (state == ERROR);

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = RUN;
        RUN: begin
          if (frame_end)          state_next = continuous ? RUN : IDLE;
          else if (stall_timeout) state_next = ERROR;
        end
        ERROR:   state_next = ERROR;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Watchdog only runs while the gates are open, so it starts from zero on entry to RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (!run || out_xfer) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done        <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      done <= frame_end;
      if (frame_end) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_canny_frame_sequencer.sv
// Self-checking bench: FIFO loopback environment, scenario table, randomized
// scenarios against a frame-level model, and hand sequences for stall/abort/reset.
module tb_canny_frame_sequencer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int TO = 16;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic        continuous;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] frame_count;
  logic        src_empty;
  logic [23:0] src_dout;
  logic        src_rd_en;
  logic        image_full;
  logic        image_wr_en;
  logic [23:0] image_din;
  logic        img_out_empty;
  logic [7:0]  img_out_dout;
  logic        img_out_rd_en;
  logic        dst_full;
  logic        dst_wr_en;
  logic [7:0]  dst_din;

  canny_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .TIMEOUT_CYCLES(TO)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .continuous    (continuous),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .frame_count   (frame_count),
    .src_empty     (src_empty),
    .src_dout      (src_dout),
    .src_rd_en     (src_rd_en),
    .image_full    (image_full),
    .image_wr_en   (image_wr_en),
    .image_din     (image_din),
    .img_out_empty (img_out_empty),
    .img_out_dout  (img_out_dout),
    .img_out_rd_en (img_out_rd_en),
    .dst_full      (dst_full),
    .dst_wr_en     (dst_wr_en),
    .dst_din       (dst_din)
  );

  typedef struct {
    int pixels;
    int frames;
    bit cont;
    int bp;
    int img_hold;
    int restart;
    int exp_left;
    int exp_frames;
  } scen_t;

  logic [23:0] src_q[$];
  logic [23:0] pipe_q[$];
  logic [23:0] model_q[$];
  logic [7:0]  dst_q[$];
  int          push_cycles[$];
  int          done_cycles[$];
  int          busy_low[$];

  int cyc = 0;
  int bp_mode = 0;
  int img_hold = 0;
  int stall_after = -1;
  int cont_frames = 0;
  int err_cycle = -1;
  int viol = 0;
  int model_fc = 0;
  int compared = 0;
  int mismatched = 0;

  logic        s_pop = 1'b0;
  logic        o_pop = 1'b0;
  logic [23:0] s_data = '0;
  logic [7:0]  o_data = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Mid-cycle: record what the DUT is about to do at the coming edge.
  always @(negedge clock) begin
    if (src_rd_en && (src_empty || image_full)) viol++;
    if (img_out_rd_en && (img_out_empty || dst_full)) viol++;
    if ((src_rd_en || img_out_rd_en) && !busy) viol++;
    if (src_rd_en != image_wr_en || img_out_rd_en != dst_wr_en) viol++;
    if (image_din != src_dout || dst_din != img_out_dout) viol++;
    s_pop  = src_rd_en;
    o_pop  = img_out_rd_en;
    s_data = image_din;
    o_data = dst_din;
    if (o_pop) push_cycles.push_back(cyc);
    if (done) done_cycles.push_back(cyc);
    if (!busy) busy_low.push_back(cyc);
    if (error && err_cycle < 0) err_cycle = cyc;
  end

  // Just after the edge: apply the transfers to the FIFO models and drive new levels.
  always @(posedge clock) begin
    logic [23:0] tmp;
    #1;
    cyc++;
    if (o_pop && pipe_q.size() > 0) begin
      tmp = pipe_q.pop_front();
      dst_q.push_back(o_data);
    end
    if (s_pop && src_q.size() > 0) begin
      tmp = src_q.pop_front();
      pipe_q.push_back(s_data);
    end
    s_pop = 1'b0;
    o_pop = 1'b0;
    if (img_hold > 0) img_hold--;
    if (cont_frames > 1 && done_cycles.size() >= cont_frames - 1) continuous = 1'b0;
    src_empty     = (src_q.size() == 0);
    src_dout      = (src_q.size() > 0) ? src_q[0] : 24'h0;
    img_out_empty = (pipe_q.size() == 0) || (stall_after >= 0 && dst_q.size() >= stall_after);
    img_out_dout  = (pipe_q.size() > 0) ? pipe_q[0][7:0] : 8'h0;
    image_full    = (img_hold > 0) || (bp_mode == 2 && $urandom_range(3) == 0);
    dst_full      = (bp_mode == 1) ? ((cyc % 2) == 1) : (bp_mode == 2 && $urandom_range(3) == 0);
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic check_output(input string name, input longint actual, input longint expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic prep(input int n);
    logic [23:0] px;
    src_q.delete(); pipe_q.delete(); dst_q.delete(); model_q.delete();
    push_cycles.delete(); done_cycles.delete(); busy_low.delete();
    bp_mode = 0; img_hold = 0; stall_after = -1; cont_frames = 0;
    continuous = 1'b0; err_cycle = -1; viol = 0;
    for (int i = 0; i < n; i++) begin
      px = 24'($urandom());
      src_q.push_back(px);
      model_q.push_back(px);
    end
    step();
    step();
  endtask

  task automatic run_scenario(input scen_t s, input string tag);
    int start_cyc;
    int last;
    int bad;
    int idx;
    prep(s.pixels);
    bp_mode     = s.bp;
    continuous  = s.cont;
    cont_frames = s.frames;
    start_cyc   = cyc;
    start       = 1'b1;
    img_hold    = s.img_hold;
    step();
    start = 1'b0;
    for (int i = 0; i < 600 && done_cycles.size() < s.frames; i++) begin
      if (s.restart > 0 && i == s.restart) start = 1'b1;
      step();
      start = 1'b0;
    end
    step(); step(); step();
    model_fc = (model_fc + s.exp_frames) & 16'hFFFF;

    check_output({tag, "/done_pulses"}, done_cycles.size(), s.exp_frames);
    check_output({tag, "/dst_count"}, dst_q.size(), s.exp_frames * N);
    bad = 0;
    for (int i = 0; i < dst_q.size() && i < model_q.size(); i++)
      if (dst_q[i] !== model_q[i][7:0]) bad++;
    check_output({tag, "/dst_seq_errors"}, bad, 0);
    check_output({tag, "/src_left"}, src_q.size(), s.exp_left);
    check_output({tag, "/frame_count"}, frame_count, model_fc);
    bad = 0;
    for (int f = 0; f < done_cycles.size(); f++) begin
      idx = (f + 1) * N - 1;
      if (idx >= push_cycles.size() || done_cycles[f] != push_cycles[idx] + 1) bad++;
    end
    check_output({tag, "/done_timing_errors"}, bad, 0);
    last = (push_cycles.size() > 0) ? push_cycles[$] : start_cyc;
    bad = 0;
    foreach (busy_low[i]) if (busy_low[i] > start_cyc && busy_low[i] <= last) bad++;
    check_output({tag, "/busy_gaps"}, bad, 0);
    check_output({tag, "/busy_end"}, busy, 0);
    check_output({tag, "/error_end"}, error, 0);
    check_output({tag, "/protocol_violations"}, viol, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    scen_t vectors[4];
    scen_t rs;
    int    exp_err;

    // pixels, frames, cont, bp, img_hold, restart, exp_left, exp_frames
    vectors[0] = '{12, 1, 1'b0, 0, 0, 0, 4, 1};
    vectors[1] = '{ 8, 1, 1'b0, 1, 3, 0, 0, 1};
    vectors[2] = '{24, 3, 1'b1, 0, 0, 0, 0, 3};
    vectors[3] = '{ 8, 1, 1'b0, 0, 0, 3, 0, 1};

    reset = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    src_empty = 1'b1; src_dout = '0; image_full = 1'b0;
    img_out_empty = 1'b1; img_out_dout = '0; dst_full = 1'b0;

    prep(4);
    check_output("reset_src_gate", src_rd_en, 0);
    check_output("reset_busy", busy, 0);
    reset = 1'b1;
    step();
    check_output("idle_busy", busy, 0);
    check_output("idle_done", done, 0);
    check_output("idle_error", error, 0);
    check_output("idle_frame_count", frame_count, 0);
    check_output("idle_src_gate", src_rd_en, 0);

    run_scenario(vectors[0], "single");
    run_scenario(vectors[1], "backpressure");
    run_scenario(vectors[2], "continuous");
    run_scenario(vectors[3], "start_while_busy");

    for (int k = 0; k < 6; k++) begin
      rs.frames     = $urandom_range(1, 3);
      rs.exp_left   = $urandom_range(0, 5);
      rs.pixels     = rs.frames * N + rs.exp_left;
      rs.cont       = (rs.frames > 1);
      rs.bp         = $urandom_range(0, 2);
      rs.img_hold   = $urandom_range(0, 4);
      rs.restart    = 0;
      rs.exp_frames = rs.frames;
      run_scenario(rs, $sformatf("rand%0d", k));
    end

    // Output side starves after three results; watchdog must trip after 16 idle RUN cycles.
    prep(12);
    stall_after = 3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 80 && err_cycle < 0; i++) step();
    exp_err = (push_cycles.size() >= 3) ? push_cycles[2] + 17 : -2;
    check_output("stall_pushes", dst_q.size(), 3);
    check_output("stall_error_cycle", err_cycle, exp_err);
    check_output("stall_error_flag", error, 1);
    check_output("stall_busy", busy, 0);
    stall_after = -1;
    step();
    step();
    check_output("stall_src_gate", src_rd_en, 0);
    check_output("stall_out_gate", img_out_rd_en, 0);
    check_output("stall_no_more_out", dst_q.size(), 3);
    check_output("stall_src_left", src_q.size(), 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_output("stall_abort_error", error, 0);
    check_output("stall_abort_busy", busy, 0);
    check_output("stall_abort_frame_count", frame_count, model_fc);

    // Abort together with start mid-frame.
    prep(12);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_output("abort_pre_src_gate", src_rd_en, 1);
    abort = 1'b1;
    start = 1'b1;
    #1;
    check_output("abort_src_gate", src_rd_en, 0);
    check_output("abort_out_gate", img_out_rd_en, 0);
    step();
    abort = 1'b0;
    start = 1'b0;
    check_output("abort_busy", busy, 0);
    step();
    step();
    check_output("abort_still_idle", busy, 0);
    check_output("abort_frame_count", frame_count, model_fc);

    // Asynchronous reset in the middle of a frame.
    prep(12);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    model_fc = 0;
    check_output("areset_busy", busy, 0);
    check_output("areset_done", done, 0);
    check_output("areset_error", error, 0);
    check_output("areset_frame_count", frame_count, 0);
    check_output("areset_src_gate", src_rd_en, 0);
    check_output("areset_out_gate", img_out_rd_en, 0);
    step();
    step();
    reset = 1'b1;
    step();
    run_scenario(vectors[0], "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/canny_frame_sequencer.md
# canny_frame_sequencer

Frame-level controller for the Canny edge pipeline. Sits on both ends of the pipeline: it meters exactly one frame (WIDTH×HEIGHT pixels) from an upstream 24-bit pixel FIFO into the pipeline's image input FIFO, and drains exactly one frame of 8-bit results from the pipeline output FIFO into a downstream sink. It reports busy, done, a frame count and a sticky stall error. Software or a top-level FSM starts, repeats or aborts frames through it.

## Interface
- WIDTH, 1280, pixels per line
- HEIGHT, 720, lines per frame
- TIMEOUT_CYCLES, 1048576, consecutive RUN cycles without an output transfer before error
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  one clock; reset is asynchronous and active-low
- start  in  1  pulse; begin a frame from IDLE
- abort  in  1  pulse; return to IDLE from any state
- continuous  in  1  sampled at frame end; 1 = restart next frame immediately
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse after the last output pixel of a frame
- error  out  1  sticky; set on stall timeout
- frame_count  out  16  completed frames; wraps
- src_empty  in  1  upstream FIFO empty
- src_dout  in  24  upstream pixel; valid while src_empty=0 (first-word fall-through)
- src_rd_en  out  1  pop upstream
- image_full  in  1  pipeline input FIFO full
- image_wr_en  out  1  push pipeline input
- image_din  out  24  = src_dout
- img_out_empty  in  1  pipeline output FIFO empty
- img_out_dout  in  8  pipeline result pixel (fall-through)
- img_out_rd_en  out  1  pop pipeline output
- dst_full  in  1  sink full
- dst_wr_en  out  1  push sink
- dst_din  out  8  = img_out_dout

## Operation
- N = WIDTH*HEIGHT. Counters in_cnt and out_cnt are CNT_W = $clog2(N+1) bits wide.
- States:
  - IDLE: all gates closed. start=1 and abort=0 → RUN, with in_cnt and out_cnt cleared.
  - RUN: busy=1. See the transfer rules below.
  - ERROR: gates closed, error=1. Left only via abort or reset.
- Input side, in RUN only: src_rd_en = image_wr_en = !src_empty & !image_full & (in_cnt < N). in_cnt increments on each transfer.
- Output side, in RUN only: img_out_rd_en = dst_wr_en = !img_out_empty & !dst_full & (out_cnt < N). out_cnt increments on each transfer.
- Both sides transfer concurrently and independently in the same cycle.
- Frame end is the output transfer that makes out_cnt = N:
  - done is registered and asserts the following cycle.
  - frame_count increments.
  - Next state is RUN with both counters cleared if continuous=1 in that cycle, else IDLE.
- Watchdog:
  - stall_cnt clears on any output transfer and on entry to RUN. It increments on each other RUN cycle.
  - stall_cnt = TIMEOUT_CYCLES-1 with no output transfer → ERROR; error sets.
  - In-flight pipeline contents are not flushed; the owner must reset the pipeline.
- abort:
  - In any state → IDLE next cycle.
  - Gates are forced closed combinationally in the abort cycle.
  - Clears error and both counters; frame_count is kept.
- start with abort=1 is ignored; abort wins. start in RUN or ERROR is ignored.
- Data paths are pure wires. The block never holds pixel data.

## Timing
- Reset values: state IDLE, busy=0, done=0, error=0, frame_count=0, counters 0.
- All handshake outputs are 0 while reset is active because they are gated by state.
- Zero-cycle forwarding: a pixel is popped and pushed in the same cycle.
- start at edge k → busy=1 and gates may open in cycle k+1.
- Last output transfer in cycle k → done=1 in cycle k+1 only. busy=0 in k+1 unless continuous=1.
- Reset asserted mid-frame: state drops to IDLE asynchronously and all gates close at once.
- Back-to-back frames in continuous mode need no idle cycle. The first transfers of the new frame may occur in the cycle done is high.

## Structure
- canny_pkg holds:
  - the state enum typedef (IDLE, RUN, ERROR)
  - a function computing CNT_W from WIDTH and HEIGHT
  - the default TIMEOUT_CYCLES localparam
- Sub-module canny_pixel_gate, parameterised by data width and N: the gate condition, the transfer counter, and a limit_reached flag. It is instantiated twice (24-bit input side, 8-bit output side).
- The top level holds the FSM, the watchdog, done and frame_count.

## Test plan
Parameters: WIDTH=4, HEIGHT=2 (N=8), TIMEOUT_CYCLES=16.
- Single frame: start with 12 pixels available upstream and pipeline modelled as a FIFO loopback → exactly 8 pops upstream, 8 pushes to dst, done one cycle after the 8th dst push, frame_count=1, 4 pixels left upstream.
- Backpressure: dst_full toggles every other cycle and image_full is held 3 cycles → no pixel lost or duplicated, dst sequence equals input sequence, done still occurs after exactly 8.
- Continuous: continuous=1, 24 pixels supplied → three done pulses, busy never drops between frames, frame_count=3.
- Stall: img_out_empty held 1 after 3 outputs → error=1 at the 16th stall cycle, gates closed. Then abort → IDLE, error=0, frame_count unchanged.
- Abort and start together in RUN → IDLE, gates closed in the same cycle. Start alone while busy → ignored.
- Async reset asserted mid-frame → all outputs 0 without waiting for a clock edge. After release a new start runs a full 8-pixel frame.
